// File: rtl/mult_div_unit.sv
// Iterative 32-step MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Define MULT_DIV_UNIT_DIV_EN to include the restoring divider datapath.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o,
    output logic             illegal_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mc_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic               neg_q;
    logic               busy_q;
    logic               done_q;
    logic               dz_q;
    logic               ill_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        rs_neg = ~op_i[0] & rs_data_i[WIDTH-1];
        rt_neg = ~op_i[0] & rt_data_i[WIDTH-1];
        rs_mag = rs_neg ? -rs_data_i : rs_data_i;
        rt_mag = rt_neg ? -rt_data_i : rt_data_i;
    end

    // acc = {partial product, remaining multiplier bits}, shifted right
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, {WIDTH{acc_q[0]}} & mc_q};
    assign prod = neg_q ? -acc_q : acc_q;

`ifdef MULT_DIV_UNIT_DIV_EN
    logic               div_q;
    logic               rneg_q;
    logic [WIDTH-1:0]   rs_q;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // acc = {remainder, dividend/quotient bits}, shifted left
    assign rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff   = rem_sh - {1'b0, mc_q};
    assign quo    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                           : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        if (div_q) begin
            if (diff[WIDTH])
                acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            else
                acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end
`else
    assign acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mc_q    <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULT_DIV_UNIT_DIV_EN
            div_q   <= 1'b0;
            rneg_q  <= 1'b0;
            rs_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            ill_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
`ifndef MULT_DIV_UNIT_DIV_EN
                        if (op_i[1]) ill_q <= 1'b1;
                        else
`endif
                        begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            neg_q   <= rs_neg ^ rt_neg;
                            mc_q    <= op_i[1] ? rt_mag : rs_mag;
                            acc_q   <= {{WIDTH{1'b0}},
                                        op_i[1] ? rs_mag : rt_mag};
`ifdef MULT_DIV_UNIT_DIV_EN
                            div_q   <= op_i[1];
                            rneg_q  <= rs_neg;
                            rs_q    <= rs_data_i;
`endif
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= FIX;
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
`ifdef MULT_DIV_UNIT_DIV_EN
                    if (div_q && mc_q == '0) begin
                        hi_q <= rs_q;
                        lo_q <= '1;
                        dz_q <= 1'b1;
                    end else if (div_q) begin
                        hi_q <= rem;
                        lo_q <= quo;
                    end else
`endif
                    begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign div_zero_o = dz_q;
    assign illegal_o  = ill_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors, queued expectations.
// Divide vectors run only when MULT_DIV_UNIT_DIV_EN is defined.
module tb_mult_div_unit;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_zero_o;
    logic        illegal_o;

    always #5 clk_i = ~clk_i;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
        .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o),
        .div_zero_o(div_zero_o), .illegal_o(illegal_o)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          ill_cnt = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic last_done;
        exp_t e;
        last_done = 1'b0;
        forever begin
            @(negedge clk_i);
            if (illegal_o) ill_cnt++;
            if (last_done) check("done_one_cycle", done_o, 0);
            last_done = done_o;
            if (done_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("hi", hi_o, e.hi);
                    check("lo", lo_o, e.lo);
                    check("div_zero", div_zero_o, e.dz);
                end
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edz,
                         input int poke);
        int lat;
        int n;
        exp_t e;
        n = 0;
        while (busy_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        op_i = o;
        rs_data_i = a;
        rt_data_i = b;
        start_i = 1'b1;
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        sb.push_back(e);
        @(negedge clk_i);
        start_i = 1'b0;
        rs_data_i = $urandom;
        rt_data_i = $urandom;
        op_i = 2'($urandom);
        check("busy_after_accept", busy_o, 1);
        lat = 0;
        while (!done_o && lat < 60) begin
            if (lat == poke) begin
                start_i = 1'b1;
                op_i = 2'b11;
                rs_data_i = 32'd9;
                rt_data_i = 32'd3;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            lat++;
        end
        start_i = 1'b0;
        check("latency", lat, 33);
        check("busy_at_done", busy_o, 0);
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    task automatic do_illegal(input logic [1:0] o, input logic [31:0] a,
                              input logic [31:0] b);
        int ill0;
        ill0 = ill_cnt;
        op_i = o;
        rs_data_i = a;
        rt_data_i = b;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("illegal_pulse", illegal_o, 1);
        check("illegal_busy", busy_o, 0);
        @(negedge clk_i);
        check("illegal_clear", illegal_o, 0);
        repeat (40) @(negedge clk_i);
        check("illegal_no_busy", busy_o, 0);
        check("illegal_hi_kept", hi_o, cur_hi);
        check("illegal_lo_kept", lo_o, cur_lo);
        check("illegal_count", ill_cnt - ill0, 1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int ill0;
        rst_i = 1'b1;
        start_i = 1'b0;
        op_i = 2'b00;
        rs_data_i = '0;
        rt_data_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        check("rst_dz", div_zero_o, 0);
        check("rst_ill", illegal_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        do_op(2'b00, 32'd7, 32'hFFFF_FFFD,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -1);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b0, -1);
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'h0, 32'h1, 1'b0, -1);
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'h0, 1'b0, -1);
        do_op(2'b01, 32'h8000_0000, 32'h2, 32'h1, 32'h0, 1'b0, -1);
        do_op(2'b00, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 1'b0, -1);

        ill0 = ill_cnt;
        do_op(2'b01, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 10);
        check("busy_start_not_flagged", ill_cnt - ill0, 0);
`ifdef MULT_DIV_UNIT_DIV_EN
        do_op(2'b11, 32'd9, 32'd3, 32'h0, 32'd3, 1'b0, -1);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
        do_op(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, -1);
        do_op(2'b10, 32'hFFFF_FFFB, 32'd0,
              32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, -1);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0, 32'h8000_0000, 1'b0, -1);
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE,
              32'h1, 32'hFFFF_FFFD, 1'b0, -1);
        do_op(2'b11, 32'hFFFF_FFFF, 32'h10,
              32'hF, 32'h0FFF_FFFF, 1'b0, -1);
`endif

        do_op(2'b01, 32'd3444014338, 32'd3570783445,
              32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, -1);
        op_i = 2'b00;
        rs_data_i = 32'h1234_5678;
        rt_data_i = 32'h10;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        check("abort_hi", hi_o, 0);
        check("abort_lo", lo_o, 0);
        check("abort_dz", div_zero_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);
        check("abort_stays_idle", busy_o, 0);
        check("abort_hi_held", hi_o, 0);
        cur_hi = '0;
        cur_lo = '0;
        do_op(2'b00, 32'h1234_5678, 32'h10,
              32'h1, 32'h2345_6780, 1'b0, -1);

`ifndef MULT_DIV_UNIT_DIV_EN
        do_illegal(2'b10, 32'd8, 32'd2);
        do_illegal(2'b11, 32'd9, 32'd3);
        do_op(2'b00, 32'hFFFF_FFFE, 32'd5,
              32'hFFFF_FFFF, 32'hFFFF_FFF6, 1'b0, -1);
`endif

        repeat (3) @(negedge clk_i);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
